// File: rtl/serial_sample_pkg.sv
// Shared types and constants for the serial sample loader family.
// Also used by the sample sequencer and the evaluator scoreboard.
package serial_sample_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WRITE    = 2'd1,
    ST_CLEARING = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_LANES  = 4;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2_ceil(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/sample_load_tracker.sv
// Per-element loaded bitmap with a running count of distinct loaded elements.
// An update sets the masked bits of one group; out-of-range groups are ignored.
module sample_load_tracker
  import serial_sample_pkg::*;
#(
  parameter  int LANES      = DEF_LANES,
  parameter  int NUM_GROUPS = 6,
  localparam int DEPTH      = LANES * NUM_GROUPS,
  localparam int IDX_W      = (clog2_ceil(NUM_GROUPS) > 1) ? clog2_ceil(NUM_GROUPS) : 1,
  localparam int CNT_W      = clog2_ceil(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_update,
  input  logic [IDX_W-1:0] i_group,
  input  logic [LANES-1:0] i_mask,
  output logic [CNT_W-1:0] o_new_count,
  output logic [CNT_W-1:0] o_loaded_count,
  output logic             o_all_loaded
);

  logic [DEPTH-1:0] r_bitmap;
  logic [CNT_W-1:0] r_count;
  logic             r_all;
  logic [LANES-1:0] w_group_bits;
  logic [LANES-1:0] w_new_bits;
  logic             w_hit;
  logic [CNT_W-1:0] w_next_count;

  always_comb begin
    w_group_bits = '0;
    w_hit        = 1'b0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      if (i_group == IDX_W'(g)) begin
        w_group_bits = r_bitmap[g*LANES +: LANES];
        w_hit        = 1'b1;
      end
    end
  end

  assign w_new_bits = w_hit ? (i_mask & ~w_group_bits) : '0;

  always_comb begin
    o_new_count = '0;
    for (int k = 0; k < LANES; k++)
      o_new_count = o_new_count + CNT_W'(w_new_bits[k]);
  end

  assign w_next_count = r_count + o_new_count;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_bitmap <= '0;
      r_count  <= '0;
      r_all    <= 1'b0;
    end else if (i_update) begin
      for (int g = 0; g < NUM_GROUPS; g++)
        if (i_group == IDX_W'(g))
          r_bitmap[g*LANES +: LANES] <= w_group_bits | i_mask;
      r_count <= w_next_count;
      r_all   <= (w_next_count == CNT_W'(DEPTH));
    end
  end

  assign o_loaded_count = r_count;
  assign o_all_loaded   = r_all;

endmodule

// File: rtl/serial_sample_buffer.sv
// Loads LANES-wide sample groups into three flat arrays over valid/ready,
// tracks loaded elements, and clears the arrays one group per cycle.
module serial_sample_buffer
  import serial_sample_pkg::*;
#(
  parameter  int DATA_W     = DEF_DATA_W,
  parameter  int LANES      = DEF_LANES,
  parameter  int NUM_GROUPS = 6,
  localparam int DEPTH      = LANES * NUM_GROUPS,
  localparam int IDX_W      = (clog2_ceil(NUM_GROUPS) > 1) ? clog2_ceil(NUM_GROUPS) : 1,
  localparam int CNT_W      = clog2_ceil(DEPTH + 1)
) (
  input  logic                    iClock,
  input  logic                    iReset,
  input  logic                    iClear,
  input  logic                    iWriteValid,
  output logic                    oWriteReady,
  input  logic [IDX_W-1:0]        iWriteIndex,
  input  logic [LANES-1:0]        iLaneMask,
  input  logic [LANES*DATA_W-1:0] iInputData,
  input  logic [LANES*DATA_W-1:0] iExpectedData,
  input  logic [LANES*DATA_W-1:0] iValidData,
  output logic [DEPTH*DATA_W-1:0] oInputSequences,
  output logic [DEPTH*DATA_W-1:0] oExpectedOutputs,
  output logic [DEPTH*DATA_W-1:0] oValidOutputs,
  output logic [CNT_W-1:0]        oLoadedCount,
  output logic                    oAllLoaded,
  output logic                    oIndexError
);

  state_t                  r_state;
  state_t                  w_state_next;
  logic [IDX_W-1:0]        r_grp_cnt;
  logic                    r_idx_err;
  logic [IDX_W-1:0]        r_idx;
  logic [LANES-1:0]        r_mask;
  logic [LANES*DATA_W-1:0] r_in;
  logic [LANES*DATA_W-1:0] r_exp;
  logic [LANES*DATA_W-1:0] r_vld;
  logic [DEPTH*DATA_W-1:0] r_inseq;
  logic [DEPTH*DATA_W-1:0] r_expout;
  logic [DEPTH*DATA_W-1:0] r_vldout;
  logic                    w_accept;
  logic                    w_clear_start;
  logic                    w_idx_ok;
  logic                    w_commit;
  logic [CNT_W-1:0]        w_new_count;

  assign oWriteReady   = (r_state == ST_IDLE) && !iClear && !iReset;
  assign w_accept      = oWriteReady && iWriteValid;
  assign w_clear_start = (r_state == ST_IDLE) && iClear;
  assign w_idx_ok      = int'(r_idx) < NUM_GROUPS;
  assign w_commit      = (r_state == ST_WRITE) && w_idx_ok;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (iClear)        w_state_next = ST_CLEARING;
        else if (w_accept) w_state_next = ST_WRITE;
      end
      ST_WRITE:    w_state_next = ST_IDLE;
      ST_CLEARING: begin
        if (r_grp_cnt == IDX_W'(NUM_GROUPS - 1)) w_state_next = ST_IDLE;
      end
      default:     w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_state   <= ST_IDLE;
      r_grp_cnt <= '0;
      r_idx_err <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_clear_start) begin
        r_grp_cnt <= '0;
        r_idx_err <= 1'b0;
      end else if (r_state == ST_CLEARING) begin
        r_grp_cnt <= r_grp_cnt + 1'b1;
      end else if ((r_state == ST_WRITE) && !w_idx_ok) begin
        r_idx_err <= 1'b1;
      end
    end
  end

  // Holding registers: payload captured at the handshake, consumed in WRITE.
  always_ff @(posedge iClock) begin
    if (w_accept) begin
      r_idx  <= iWriteIndex;
      r_mask <= iLaneMask;
      r_in   <= iInputData;
      r_exp  <= iExpectedData;
      r_vld  <= iValidData;
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_inseq  <= '0;
      r_expout <= '0;
      r_vldout <= '0;
    end else if (w_commit) begin
      for (int g = 0; g < NUM_GROUPS; g++) begin
        for (int k = 0; k < LANES; k++) begin
          if ((r_idx == IDX_W'(g)) && r_mask[k]) begin
            r_inseq [(g*LANES+k)*DATA_W +: DATA_W] <= r_in [k*DATA_W +: DATA_W];
            r_expout[(g*LANES+k)*DATA_W +: DATA_W] <= r_exp[k*DATA_W +: DATA_W];
            r_vldout[(g*LANES+k)*DATA_W +: DATA_W] <= r_vld[k*DATA_W +: DATA_W];
          end
        end
      end
    end else if (r_state == ST_CLEARING) begin
      for (int g = 0; g < NUM_GROUPS; g++) begin
        if (r_grp_cnt == IDX_W'(g)) begin
          r_inseq [g*LANES*DATA_W +: LANES*DATA_W] <= '0;
          r_expout[g*LANES*DATA_W +: LANES*DATA_W] <= '0;
          r_vldout[g*LANES*DATA_W +: LANES*DATA_W] <= '0;
        end
      end
    end
  end

  sample_load_tracker #(
    .LANES      (LANES),
    .NUM_GROUPS (NUM_GROUPS)
  ) u_tracker (
    .clk            (iClock),
    .rst            (iReset),
    .i_clear        (w_clear_start),
    .i_update       (w_commit),
    .i_group        (r_idx),
    .i_mask         (r_mask),
    .o_new_count    (w_new_count),
    .o_loaded_count (oLoadedCount),
    .o_all_loaded   (oAllLoaded)
  );

  assign oInputSequences  = r_inseq;
  assign oExpectedOutputs = r_expout;
  assign oValidOutputs    = r_vldout;
  assign oIndexError      = r_idx_err;

endmodule

// File: tb/tb_serial_sample_buffer.sv
// Directed bench for serial_sample_buffer with a queue-based scoreboard:
// each accepted write pushes its expected post-write state, a monitor pops it.
module tb_serial_sample_buffer;

  localparam int DW    = 8;
  localparam int L     = 4;
  localparam int NG    = 6;
  localparam int DEPTH = L * NG;
  localparam int IW    = 3;
  localparam int CW    = 5;
  localparam int AW    = DEPTH * DW;

  logic          iClock = 1'b0;
  logic          iReset;
  logic          iClear;
  logic          iWriteValid;
  logic          oWriteReady;
  logic [IW-1:0] iWriteIndex;
  logic [L-1:0]  iLaneMask;
  logic [L*DW-1:0] iInputData, iExpectedData, iValidData;
  logic [AW-1:0] oInputSequences, oExpectedOutputs, oValidOutputs;
  logic [CW-1:0] oLoadedCount;
  logic          oAllLoaded;
  logic          oIndexError;

  serial_sample_buffer dut (
    .iClock           (iClock),
    .iReset           (iReset),
    .iClear           (iClear),
    .iWriteValid      (iWriteValid),
    .oWriteReady      (oWriteReady),
    .iWriteIndex      (iWriteIndex),
    .iLaneMask        (iLaneMask),
    .iInputData       (iInputData),
    .iExpectedData    (iExpectedData),
    .iValidData       (iValidData),
    .oInputSequences  (oInputSequences),
    .oExpectedOutputs (oExpectedOutputs),
    .oValidOutputs    (oValidOutputs),
    .oLoadedCount     (oLoadedCount),
    .oAllLoaded       (oAllLoaded),
    .oIndexError      (oIndexError)
  );

  always #5 iClock = ~iClock;

  typedef struct {
    logic [CW-1:0] cnt;
    logic          all;
    logic          err;
    logic [AW-1:0] ins;
    logic [AW-1:0] exps;
    logic [AW-1:0] vlds;
  } exp_t;

  exp_t sbq[$];
  logic [AW-1:0] m_ins, m_exp, m_vld;
  int n_checks = 0;
  int n_err    = 0;
  int mon_st   = 0;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: handshake seen at negedge n, ready low at n+1, results at n+2.
  initial begin
    exp_t e;
    forever begin
      @(negedge iClock);
      if (iReset) begin
        mon_st = 0;
      end else if (mon_st == 2) begin
        mon_st = 0;
        if (sbq.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL sb_empty: got no expected entry for a completed write");
        end else begin
          e = sbq.pop_front();
          chk("sb_count",  oLoadedCount,     e.cnt);
          chk("sb_all",    oAllLoaded,       e.all);
          chk("sb_idxerr", oIndexError,      e.err);
          chk("sb_ins",    oInputSequences,  e.ins);
          chk("sb_exp",    oExpectedOutputs, e.exps);
          chk("sb_vld",    oValidOutputs,    e.vlds);
          chk("sb_ready_back", oWriteReady,  1'b1);
        end
      end else if (mon_st == 1) begin
        chk("sb_ready_low", oWriteReady, 1'b0);
        mon_st = 2;
      end
      if (!iReset && mon_st == 0 && iWriteValid && oWriteReady) mon_st = 1;
    end
  end

  task automatic do_write(input logic [IW-1:0] idx, input logic [L-1:0] mask,
                          input logic [L*DW-1:0] din, input logic [L*DW-1:0] dexp,
                          input logic [L*DW-1:0] dvld, input logic [CW-1:0] ecnt,
                          input logic eall, input logic eerr, input bit hold,
                          output int waited);
    exp_t e;
    iWriteIndex   = idx;
    iLaneMask     = mask;
    iInputData    = din;
    iExpectedData = dexp;
    iValidData    = dvld;
    iWriteValid   = 1'b1;
    waited = 0;
    do begin
      @(negedge iClock);
      waited++;
    end while (!oWriteReady && waited < 20);
    if (!oWriteReady) begin
      n_checks++; n_err++;
      $display("FAIL hs_timeout: got ready=0 after %0d cycles required ready=1", waited);
      iWriteValid = 1'b0;
      return;
    end
    @(posedge iClock);
    #1;
    if (int'(idx) < NG) begin
      for (int k = 0; k < L; k++) begin
        if (mask[k]) begin
          m_ins[(int'(idx)*L+k)*DW +: DW] = din [k*DW +: DW];
          m_exp[(int'(idx)*L+k)*DW +: DW] = dexp[k*DW +: DW];
          m_vld[(int'(idx)*L+k)*DW +: DW] = dvld[k*DW +: DW];
        end
      end
    end
    e.cnt = ecnt; e.all = eall; e.err = eerr;
    e.ins = m_ins; e.exps = m_exp; e.vlds = m_vld;
    sbq.push_back(e);
    if (!hold) iWriteValid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || mon_st != 0) && n < 20) begin
      @(negedge iClock);
      n++;
    end
    if (sbq.size() != 0 || mon_st != 0) begin
      n_checks++; n_err++;
      $display("FAIL drain_timeout: got %0d pending required 0", sbq.size());
    end
    @(posedge iClock);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [CW-1:0] cnt, input logic all,
                           input logic err);
    chk({tag, "_count"},  oLoadedCount,     cnt);
    chk({tag, "_all"},    oAllLoaded,       all);
    chk({tag, "_idxerr"}, oIndexError,      err);
    chk({tag, "_ins"},    oInputSequences,  m_ins);
    chk({tag, "_exp"},    oExpectedOutputs, m_exp);
    chk({tag, "_vld"},    oValidOutputs,    m_vld);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, sum, n;
    logic [CW-1:0] fill_cnt [NG];
    fill_cnt = '{5'd8, 5'd12, 5'd12, 5'd16, 5'd20, 5'd24};
    m_ins = '0; m_exp = '0; m_vld = '0;
    iReset = 1'b1; iClear = 1'b0; iWriteValid = 1'b0;
    iWriteIndex = '0; iLaneMask = '0;
    iInputData = '0; iExpectedData = '0; iValidData = '0;

    // Reset state
    @(negedge iClock);
    chk("rst_ready", oWriteReady, 1'b0);
    @(posedge iClock); #1;
    @(posedge iClock); #1;
    iReset = 1'b0;
    @(negedge iClock);
    chk("post_rst_ready", oWriteReady, 1'b1);
    chk_state("post_rst", 5'd0, 1'b0, 1'b0);
    @(posedge iClock); #1;

    // Basic write
    do_write(3'd2, 4'b1111, 32'h44332211, 32'h0, 32'h0, 5'd4, 1'b0, 1'b0, 1'b0, w);
    drain();
    chk("elem8",  oInputSequences[8*DW +: DW],  8'h11);
    chk("elem11", oInputSequences[11*DW +: DW], 8'h44);

    // Partial mask, then identical rewrite
    do_write(3'd0, 4'b0101, 32'h0, 32'hDDCCBBAA, 32'h0, 5'd6, 1'b0, 1'b0, 1'b0, w);
    drain();
    chk("exp0", oExpectedOutputs[0*DW +: DW], 8'hAA);
    chk("exp1", oExpectedOutputs[1*DW +: DW], 8'h00);
    chk("exp2", oExpectedOutputs[2*DW +: DW], 8'hCC);
    chk("exp3", oExpectedOutputs[3*DW +: DW], 8'h00);
    do_write(3'd0, 4'b0101, 32'h0, 32'hDDCCBBAA, 32'h0, 5'd6, 1'b0, 1'b0, 1'b0, w);
    drain();

    // Fill all groups back-to-back with valid held
    sum = 0;
    for (int g = 0; g < NG; g++) begin
      do_write(IW'(g), 4'b1111, 32'h10203040 + 32'(g), ~(32'h10203040 + 32'(g)),
               32'hFF00FF00 ^ 32'(g), fill_cnt[g], (g == NG-1), 1'b0, (g != NG-1), w);
      sum += w;
    end
    chk("fill_cycles", sum + 1, 12);
    drain();
    chk("fill_all", oAllLoaded, 1'b1);

    // Out-of-range index, then an all-zero-mask write
    do_write(3'd6, 4'b1111, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 5'd24, 1'b1, 1'b1, 1'b0, w);
    drain();
    do_write(3'd1, 4'b0000, 32'h55555555, 32'h55555555, 32'h55555555, 5'd24, 1'b1, 1'b1, 1'b0, w);
    drain();

    // Clear colliding with a write
    iClear = 1'b1; iWriteValid = 1'b1; iWriteIndex = 3'd3; iLaneMask = 4'b1111;
    iInputData = 32'h99999999;
    @(negedge iClock);
    chk("collide_ready", oWriteReady, 1'b0);
    @(posedge iClock); #1;
    iClear = 1'b0; iWriteValid = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge iClock);
      if (oWriteReady) break;
      n++;
    end
    chk("clear_ready_low_cycles", n, 6);
    m_ins = '0; m_exp = '0; m_vld = '0;
    chk_state("post_clear", 5'd0, 1'b0, 1'b0);
    @(posedge iClock); #1;

    // Reset in the third CLEARING cycle
    do_write(3'd5, 4'b1111, 32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4, 5'd4, 1'b0, 1'b0, 1'b0, w);
    drain();
    iClear = 1'b1;
    @(posedge iClock); #1;
    iClear = 1'b0;
    @(posedge iClock); #1;
    @(posedge iClock); #1;
    iReset = 1'b1;
    @(posedge iClock);
    @(negedge iClock);
    m_ins = '0; m_exp = '0; m_vld = '0;
    chk("midclr_rst_ready", oWriteReady, 1'b0);
    chk_state("midclr_rst", 5'd0, 1'b0, 1'b0);
    @(posedge iClock); #1;
    iReset = 1'b0;
    @(negedge iClock);
    chk("midclr_release_ready", oWriteReady, 1'b1);
    @(posedge iClock); #1;
    do_write(3'd3, 4'b1000, 32'h77000000, 32'h0, 32'h0, 5'd1, 1'b0, 1'b0, 1'b0, w);
    drain();
    chk("elem15", oInputSequences[15*DW +: DW], 8'h77);

    chk("sb_leftover", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_sample_buffer.md
Name: serial_sample_buffer

Overview:
Parametrised successor to the serial sample loader for the genetic-circuit evaluator. It accepts LANES samples per write over a valid/ready handshake and scatters them into three flat arrays: input sequences, expected outputs and valid-output masks. It tracks which elements have been loaded and flags out-of-range writes. A multi-cycle clear empties the arrays so a new sample set can be loaded.

Parameters:
DATA_W, 8, bit width of one sample element
LANES, 4, elements carried per write (one write group)
NUM_GROUPS, 6, number of write groups; DEPTH = LANES*NUM_GROUPS is a derived localparam
IDX_W, derived, max(1, clog2(NUM_GROUPS)), group-index width
CNT_W, derived, clog2(DEPTH+1), loaded-count width

Ports:
iClock  in  1  single clock, rising edge
iReset  in  1  reset, synchronous, active-high
iClear  in  1  request to clear all stored data (sampled in IDLE only)
iWriteValid  in  1  write request
oWriteReady  out  1  write can be accepted this cycle
iWriteIndex  in  IDX_W  target group index
iLaneMask  in  LANES  per-lane write enable
iInputData  in  LANES*DATA_W  lane k = bits [k*DATA_W +: DATA_W]
iExpectedData  in  LANES*DATA_W  same lane packing
iValidData  in  LANES*DATA_W  same lane packing
oInputSequences  out  DEPTH*DATA_W  element e = bits [e*DATA_W +: DATA_W]
oExpectedOutputs  out  DEPTH*DATA_W  same packing
oValidOutputs  out  DEPTH*DATA_W  same packing
oLoadedCount  out  CNT_W  number of distinct elements written since reset/clear
oAllLoaded  out  1  oLoadedCount == DEPTH
oIndexError  out  1  sticky: an accepted write had iWriteIndex >= NUM_GROUPS

Behaviour:
- Clock and reset: one clock (iClock). Reset (iReset) is synchronous and active-high.
- Reset: state IDLE; arrays, loaded bitmap (DEPTH bits), count, oAllLoaded and oIndexError all 0. oWriteReady is 0 while iReset is high. Reset overrides any state, including mid-CLEARING and mid-WRITE.
- States: IDLE, WRITE, CLEARING.
- oWriteReady = (state==IDLE) && !iClear && !iReset. Clear wins over a simultaneous write; that write is not accepted.
- IDLE:
  - On iClear: go to CLEARING; group counter = 0; bitmap, count and oIndexError are cleared at this edge.
  - Otherwise, on iWriteValid && oWriteReady: capture index, mask and the three data buses into holding registers; go to WRITE.
- WRITE (exactly one cycle), then return to IDLE:
  - Index in range: for each lane k with mask[k]=1, element idx*LANES+k in all three arrays takes the held lane-k data. Its bitmap bit is set, and the count increments by the number of newly set bits.
  - Lanes with mask[k]=0 are unchanged.
  - Index out of range: no array or bitmap change; oIndexError set to 1.
- Latency: handshake at edge T; arrays, count and oAllLoaded update at edge T+1; oWriteReady is low during the cycle after T. Maximum throughput is one write per 2 cycles.
- Rewrite: rewriting an already-loaded element overwrites the data; the count does not increment.
- Mask 0: an all-zero mask is still accepted and consumes a WRITE cycle, with no effect.
- CLEARING: each cycle zeroes one group (LANES elements, all three arrays) at the counter index. After group NUM_GROUPS-1 is cleared, go to IDLE. iClear and iWriteValid are ignored in this state; oWriteReady is 0 for exactly NUM_GROUPS cycles.
- oAllLoaded is a registered compare, updated on the same edge as the count.
- Held iWriteValid: a request held high across WRITE is re-accepted on return to IDLE, i.e. a second write with the same payload.

Decomposition:
- Package serial_sample_pkg holds:
  - state enum (IDLE, WRITE, CLEARING);
  - a clog2-style helper function;
  - default DATA_W/LANES constants shared with the sample sequencer.
- One natural sub-module: sample_load_tracker. It holds the DEPTH-bit bitmap, takes a group index and lane mask, and produces the newly-set popcount, oLoadedCount and oAllLoaded. It is reused by the evaluator scoreboard.

Test Plan:
(Defaults: DATA_W=8, LANES=4, NUM_GROUPS=6, DEPTH=24.)
1. Basic write: after reset, write idx=2, mask=4'b1111, iInputData=0x44332211 -> one edge later elements 8..11 = 11,22,33,44; count=4; oAllLoaded=0; oWriteReady low for exactly 1 cycle.
2. Partial mask and rewrite: write idx=0, mask=4'b0101, iExpectedData=0xDDCCBBAA -> expected element 0=AA, element 2=CC, elements 1 and 3 remain 00; count +2. Repeating the same write -> count unchanged.
3. Fill: write all six groups with full masks back-to-back (valid held) -> count=24 and oAllLoaded=1 at the edge after the 6th handshake; 12 cycles total.
4. Out of range: write idx=6 -> no array change, count unchanged, oIndexError=1, still 1 after a further valid write; cleared only by clear or reset.
5. Clear with collision: from the full state assert iClear together with iWriteValid -> write not accepted; oWriteReady low for 6 cycles; then all arrays 0, count 0, oAllLoaded 0, oIndexError 0.
6. Reset mid-clear: assert iReset in the 3rd CLEARING cycle -> next cycle state IDLE, all outputs 0; oWriteReady=1 once iReset is released.
